// File: rtl/accel_run_sequencer.sv
// Host-side run sequencer for a Bambu `main` accelerator: reset it, load the input array,
// start it, wait for done (with timeout), then unload results through a 1-entry buffer.
module accel_run_sequencer #(
    parameter int unsigned NUM_WORDS      = 100,
    parameter int unsigned BASE_ADDR      = 0,
    parameter int unsigned TIMEOUT_CYCLES = 200000000
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         cmd_start,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [31:0]  out_data,
    output logic         busy,
    output logic         run_done,
    output logic         timed_out,
    output logic [31:0]  cycle_count,
    output logic         acc_reset,
    output logic         start_port,
    input  logic         done_port,
    output logic [1:0]   S_oe_ram,
    output logic [1:0]   S_we_ram,
    output logic [17:0]  S_addr_ram,
    output logic [127:0] S_Wdata_ram,
    output logic [13:0]  S_data_ram_size,
    input  logic [127:0] Sout_Rdata_ram,
    input  logic [1:0]   Sout_DataRdy
);

    localparam int unsigned IDX_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);
    localparam logic [8:0]  BASE_A    = 9'(BASE_ADDR);
    localparam logic [31:0] TIMEOUT   = 32'(TIMEOUT_CYCLES);
    localparam logic [6:0]  SIZE_WORD = 7'd32;

    typedef enum logic [2:0] {IDLE, ARST, LOAD, START, RUN, UNLOAD} state_t;

    state_t            state_q, state_d;
    logic              arst_cnt_q, arst_cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d, idx_inc;
    logic              we_q, we_d, oe_q, oe_d;
    logic [8:0]        addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [6:0]        size_q, size_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic [31:0]       out_data_q, out_data_d;
    logic              busy_q, busy_d;
    logic              run_done_q, run_done_d;
    logic              timed_out_q, timed_out_d;
    logic [31:0]       cycle_count_q, cycle_count_d;
    logic              acc_reset_q, acc_reset_d;
    logic              start_port_q, start_port_d;
    logic              unused_inputs;

    function automatic logic [8:0] word_addr(input logic [IDX_W-1:0] i);
        return BASE_A + 9'({i, 2'b00});
    endfunction

    assign idx_inc = idx_q + 1'b1;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            arst_cnt_q    <= 1'b0;
            idx_q         <= '0;
            we_q          <= 1'b0;
            oe_q          <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            size_q        <= '0;
            in_ready_q    <= 1'b0;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            busy_q        <= 1'b0;
            run_done_q    <= 1'b0;
            timed_out_q   <= 1'b0;
            cycle_count_q <= '0;
            acc_reset_q   <= 1'b1;
            start_port_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            arst_cnt_q    <= arst_cnt_d;
            idx_q         <= idx_d;
            we_q          <= we_d;
            oe_q          <= oe_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            size_q        <= size_d;
            in_ready_q    <= in_ready_d;
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
            busy_q        <= busy_d;
            run_done_q    <= run_done_d;
            timed_out_q   <= timed_out_d;
            cycle_count_q <= cycle_count_d;
            acc_reset_q   <= acc_reset_d;
            start_port_q  <= start_port_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        arst_cnt_d    = arst_cnt_q;
        idx_d         = idx_q;
        we_d          = we_q;
        oe_d          = oe_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        size_d        = size_q;
        out_valid_d   = out_valid_q;
        out_data_d    = out_data_q;
        run_done_d    = 1'b0;
        timed_out_d   = timed_out_q;
        cycle_count_d = cycle_count_q;

        case (state_q)
            IDLE: begin
                if (cmd_start) begin
                    timed_out_d = 1'b0;
                    idx_d       = '0;
                    arst_cnt_d  = 1'b0;
                    state_d     = ARST;
                end
            end
            ARST: begin
                if (arst_cnt_q) state_d = LOAD;
                else            arst_cnt_d = 1'b1;
            end
            LOAD: begin
                if (we_q) begin
                    if (Sout_DataRdy[0]) begin
                        we_d   = 1'b0;
                        size_d = '0;
                        if (idx_q == LAST_IDX) begin
                            idx_d   = '0;
                            state_d = START;
                        end else begin
                            idx_d = idx_inc;
                        end
                    end
                end else if (in_ready_q && in_valid) begin
                    we_d    = 1'b1;
                    addr_d  = word_addr(idx_q);
                    wdata_d = in_data;
                    size_d  = SIZE_WORD;
                end
            end
            START: begin
                cycle_count_d = 32'd1;
                state_d       = RUN;
            end
            RUN: begin
                // The done cycle itself is counted, so the increment is unconditional.
                cycle_count_d = cycle_count_q + 32'd1;
                if (done_port) begin
                    state_d = UNLOAD;
                end else if (cycle_count_d >= TIMEOUT) begin
                    timed_out_d = 1'b1;
                    run_done_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            UNLOAD: begin
                if (oe_q) begin
                    if (Sout_DataRdy[0]) begin
                        oe_d        = 1'b0;
                        size_d      = '0;
                        out_data_d  = Sout_Rdata_ram[31:0];
                        out_valid_d = 1'b1;
                    end
                end else if (out_valid_q) begin
                    // Next read is issued in the same cycle the buffer drains.
                    if (out_ready) begin
                        out_valid_d = 1'b0;
                        if (idx_q == LAST_IDX) begin
                            idx_d      = '0;
                            run_done_d = 1'b1;
                            state_d    = IDLE;
                        end else begin
                            idx_d  = idx_inc;
                            oe_d   = 1'b1;
                            addr_d = word_addr(idx_inc);
                            size_d = SIZE_WORD;
                        end
                    end
                end else begin
                    oe_d   = 1'b1;
                    addr_d = word_addr(idx_q);
                    size_d = SIZE_WORD;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d       = (state_d != IDLE);
        acc_reset_d  = (state_d != ARST);
        start_port_d = (state_d == START);
        in_ready_d   = (state_d == LOAD) && !we_d;
    end

    assign in_ready        = in_ready_q;
    assign out_valid       = out_valid_q;
    assign out_data        = out_data_q;
    assign busy            = busy_q;
    assign run_done        = run_done_q;
    assign timed_out       = timed_out_q;
    assign cycle_count     = cycle_count_q;
    assign acc_reset       = acc_reset_q;
    assign start_port      = start_port_q;
    assign S_oe_ram        = {1'b0, oe_q};
    assign S_we_ram        = {1'b0, we_q};
    assign S_addr_ram      = {9'd0, addr_q};
    assign S_Wdata_ram     = {96'd0, wdata_q};
    assign S_data_ram_size = {7'd0, size_q};
    assign unused_inputs   = ^{Sout_Rdata_ram[127:32], Sout_DataRdy[1]};

endmodule
